// File: rtl/valu_oprnd_issue.sv
// Operand issue stage for the VALU: mirrors A/B queue occupancy, pops operand pairs
// and presents them to the ALU over valid/ready. Optional macro: VALU_ISSUE_PIPE_EN.
module valu_oprnd_issue #(
    parameter int DATA_W = 32,
    parameter int QDEPTH = 5,
    parameter int VLEN_W = 6,
    localparam int CNT_W = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [VLEN_W-1:0] vl,
    input  logic              enq_a,
    input  logic              enq_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              rd_a,
    output logic              rd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic              alu_last,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [1:0]        dbg_state,
    output logic [CNT_W-1:0]  dbg_cnt_a,
    output logic [CNT_W-1:0]  dbg_cnt_b
);

    // ALU handshake: a pair transfers on a rising edge where alu_valid && alu_ready;
    // once alu_valid is high, alu_a/alu_b/alu_last stay stable until that transfer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CAP   = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt_a;
    logic [CNT_W-1:0]    cnt_b;
    logic [VLEN_W-1:0]   remaining;
    logic                can_read;
    logic                rd_fire;
    logic                start_acc;
    logic                full_a;
    logic                full_b;

    // The queue gives Write priority over Read, so never read during an enqueue.
    assign can_read  = (cnt_a != '0) && (cnt_b != '0) && !enq_a && !enq_b;
    assign start_acc = (state == IDLE) && start;
    assign full_a    = (cnt_a == CNT_W'(QDEPTH));
    assign full_b    = (cnt_b == CNT_W'(QDEPTH));

`ifdef VALU_ISSUE_PIPE_EN
    assign rd_fire = can_read &&
                     ((state == REQ) ||
                      ((state == ISSUE) && alu_ready && (remaining > VLEN_W'(1))));
`else
    assign rd_fire = can_read && (state == REQ);
`endif

    assign rd_a      = rd_fire;
    assign rd_b      = rd_fire;
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign dbg_cnt_a = cnt_a;
    assign dbg_cnt_b = cnt_b;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_a <= '0;
        end else if (enq_a) begin
            if (!full_a) cnt_a <= cnt_a + CNT_W'(1);
        end else if (rd_fire) begin
            cnt_a <= cnt_a - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_b <= '0;
        end else if (enq_b) begin
            if (!full_b) cnt_b <= cnt_b + CNT_W'(1);
        end else if (rd_fire) begin
            cnt_b <= cnt_b - CNT_W'(1);
        end
    end

    // A fresh overflow wins over the clear from an accepted start in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_ovf <= 1'b0;
        end else if ((enq_a && full_a) || (enq_b && full_b)) begin
            err_ovf <= 1'b1;
        end else if (start_acc) begin
            err_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            remaining <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_valid <= 1'b0;
            alu_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= vl;
                        if (vl == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (rd_fire) state <= CAP;
                end
                CAP: begin
                    alu_a     <= data_a;
                    alu_b     <= data_b;
                    alu_valid <= 1'b1;
                    alu_last  <= (remaining == VLEN_W'(1));
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (alu_ready) begin
                        remaining <= remaining - VLEN_W'(1);
                        alu_valid <= 1'b0;
                        alu_last  <= 1'b0;
                        if (remaining == VLEN_W'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (rd_fire) begin
                            // only reachable with the pipelined issue path
                            state <= CAP;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_valu_oprnd_issue.sv
// Bench for valu_oprnd_issue: emulates the two operand queues and checks issued pairs,
// occupancy, overflow flag, handshake stability and timing against a stream model.
module tb_valu_oprnd_issue;
    localparam int DATA_W = 32;
    localparam int QDEPTH = 5;
    localparam int VLEN_W = 6;
`ifdef VALU_ISSUE_PIPE_EN
    localparam int SPACING = 2;
`else
    localparam int SPACING = 3;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [VLEN_W-1:0] vl = '0;
    logic              enq_a = 1'b0;
    logic              enq_b = 1'b0;
    logic [DATA_W-1:0] data_a = '0;
    logic [DATA_W-1:0] data_b = '0;
    logic              rd_a, rd_b;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic              alu_valid, alu_last;
    logic              alu_ready = 1'b0;
    logic              busy, done, err_ovf;
    logic [1:0]        dbg_state;
    logic [2:0]        dbg_cnt_a, dbg_cnt_b;

    valu_oprnd_issue dut (
        .clk(clk), .rstn(rstn), .start(start), .vl(vl),
        .enq_a(enq_a), .enq_b(enq_b), .data_a(data_a), .data_b(data_b),
        .rd_a(rd_a), .rd_b(rd_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_last(alu_last),
        .busy(busy), .done(done), .err_ovf(err_ovf),
        .dbg_state(dbg_state), .dbg_cnt_a(dbg_cnt_a), .dbg_cnt_b(dbg_cnt_b)
    );

    always #5 clk = ~clk;

    // queue write-port data driven by the bench alongside enq_a/enq_b
    logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;

    // queue emulation and stream model
    logic [DATA_W-1:0] q_a[$], q_b[$];
    logic [DATA_W-1:0] exp_a[$], exp_b[$];
    logic              exp_err = 1'b0;
    bit                full_a, full_b;
    logic              p_rd_a = 0, p_rd_b = 0, p_enq_a = 0, p_enq_b = 0, p_start = 0;
    logic [DATA_W-1:0] p_wa = '0, p_wb = '0;
    int                cyc = 0;

    // scoreboard / bookkeeping (owned by the stimulus process)
    int n_cmp = 0, n_err = 0;
    int idx_a = 0, idx_b = 0;
    int xfer_cnt = 0, done_cnt = 0, rd_cnt = 0;
    int op_first = 0, cur_vl = 0;
    int xfer_cyc[$];
    logic prev_v = 0, prev_x = 0, prev_l = 0, prev_d = 0;
    logic [DATA_W-1:0] prev_a = '0, prev_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_a.delete();
            q_b.delete();
            data_a  <= '0;
            data_b  <= '0;
            exp_err <= 1'b0;
        end else begin
            full_a = (q_a.size() >= QDEPTH);
            full_b = (q_b.size() >= QDEPTH);
            if (p_rd_a && q_a.size() != 0) data_a <= q_a.pop_front();
            if (p_rd_b && q_b.size() != 0) data_b <= q_b.pop_front();
            if (p_enq_a && !full_a) begin q_a.push_back(p_wa); exp_a.push_back(p_wa); end
            if (p_enq_b && !full_b) begin q_b.push_back(p_wb); exp_b.push_back(p_wb); end
            exp_err <= (p_enq_a && full_a) || (p_enq_b && full_b) || (exp_err && !p_start);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs at every falling edge: per-cycle checks, then latch what the queues see next edge.
    task automatic sample();
        logic xfer;
        if (!rstn) begin
            prev_v = 0; prev_x = 0; prev_d = 0;
            idx_a = exp_a.size(); idx_b = exp_b.size();
            p_rd_a = 0; p_rd_b = 0; p_enq_a = 0; p_enq_b = 0; p_start = 0;
            return;
        end
        chk("cnt_a", dbg_cnt_a, q_a.size());
        chk("cnt_b", dbg_cnt_b, q_b.size());
        chk("err_ovf", err_ovf, exp_err);
        chk("rd_pair", rd_a, rd_b);
        if (rd_a) begin
            rd_cnt++;
            chk("rd_legal", (q_a.size() != 0) && (q_b.size() != 0) && !enq_a && !enq_b, 1);
        end
        if (prev_v && !prev_x)
            chk("hold", {alu_valid, alu_last, alu_a, alu_b}, {1'b1, prev_l, prev_a, prev_b});
        xfer = alu_valid && alu_ready;
        if (xfer) begin
            if (idx_a >= exp_a.size() || idx_b >= exp_b.size()) begin
                chk("xfer_avail", 0, 1);
            end else begin
                chk("pair", {alu_a, alu_b}, {exp_a[idx_a], exp_b[idx_b]});
                idx_a++; idx_b++;
            end
            chk("last", alu_last, (xfer_cnt - op_first) == (cur_vl - 1));
            xfer_cyc.push_back(cyc);
            xfer_cnt++;
        end
        if (done) begin
            chk("done_pulse", prev_d, 0);
            done_cnt++;
        end
        prev_d = done; prev_v = alu_valid; prev_x = xfer; prev_l = alu_last;
        prev_a = alu_a; prev_b = alu_b;
        p_rd_a = rd_a; p_rd_b = rd_b; p_enq_a = enq_a; p_enq_b = enq_b;
        p_wa = wdata_a; p_wb = wdata_b; p_start = start;
    endtask

    task automatic tick(input logic ea, input logic [DATA_W-1:0] da,
                        input logic eb, input logic [DATA_W-1:0] db, input logic rdy);
        @(posedge clk); #1;
        start = 0; enq_a = ea; wdata_a = da; enq_b = eb; wdata_b = db; alu_ready = rdy;
        @(negedge clk);
        sample();
    endtask

    task automatic start_op(input int v);
        @(posedge clk); #1;
        start = 1; vl = VLEN_W'(v); enq_a = 0; enq_b = 0; alu_ready = 1;
        cur_vl = v; op_first = xfer_cnt;
        @(negedge clk);
        sample();
    endtask

    task automatic wait_done(input int prev, input bit rnd);
        int k = 0;
        while (done_cnt == prev && k < 400) begin
            if (rnd)
                tick(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                     $urandom_range(0, 3) != 0);
            else
                tick(0, 0, 0, 0, 1);
            k++;
        end
        chk("done_timeout", done_cnt != prev, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, d0, r0, v;
        logic [DATA_W-1:0] ha, hb;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample();
        chk("reset_out", {rd_a, rd_b, alu_valid, alu_last, busy, done, err_ovf,
                          alu_a, alu_b, dbg_cnt_a, dbg_cnt_b}, 0);
        @(posedge clk); #1;
        rstn = 1;

        // 1: three preloaded pairs, latency and throughput
        tick(1, 1, 1, 10, 1);
        tick(1, 2, 1, 20, 1);
        tick(1, 3, 1, 30, 1);
        tick(0, 0, 0, 0, 1);
        x0 = xfer_cnt; d0 = done_cnt;
        start_op(3);
        tick(0, 0, 0, 0, 1);
        chk("t1_busy", busy, 1);
        chk("t1_rd", rd_a, 1);
        tick(0, 0, 0, 0, 1);
        chk("t1_valid_cap", alu_valid, 0);
        tick(0, 0, 0, 0, 1);
        chk("t1_valid_3rd", alu_valid, 1);
        chk("t1_first_pair", {alu_a, alu_b}, {32'd1, 32'd10});
        wait_done(d0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("t1_xfers", xfer_cnt - x0, 3);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_gap0", xfer_cyc[x0 + 1] - xfer_cyc[x0], SPACING);
        chk("t1_gap1", xfer_cyc[x0 + 2] - xfer_cyc[x0 + 1], SPACING);
        chk("t1_cnt", {dbg_cnt_a, dbg_cnt_b}, 0);

        // 2: vl == 0
        r0 = rd_cnt; d0 = done_cnt;
        start_op(0);
        tick(0, 0, 0, 0, 1);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        tick(0, 0, 0, 0, 1);
        chk("t2_done_low", done, 0);
        chk("t2_busy_low", busy, 0);
        chk("t2_no_rd", rd_cnt - r0, 0);
        chk("t2_done_cnt", done_cnt - d0, 1);

        // 3: B empty stalls in REQ, then B arrives
        tick(1, $urandom, 0, 0, 1);
        tick(1, $urandom, 0, 0, 1);
        r0 = rd_cnt; x0 = xfer_cnt; d0 = done_cnt;
        start_op(2);
        repeat (6) tick(0, 0, 0, 0, 1);
        chk("t3_busy", busy, 1);
        chk("t3_no_rd", rd_cnt - r0, 0);
        chk("t3_no_xfer", xfer_cnt - x0, 0);
        tick(0, 0, 1, 5, 1);
        tick(0, 0, 1, 6, 1);
        wait_done(d0, 0);
        chk("t3_xfers", xfer_cnt - x0, 2);
        chk("t3_b_last", alu_b, 6);

        // 4: enqueue collides with the read opportunity
        tick(1, $urandom, 1, $urandom, 1);
        tick(0, 0, 0, 0, 1);
        d0 = done_cnt;
        start_op(1);
        tick(1, $urandom, 0, 0, 1);
        chk("t4_rd_withheld", rd_a, 0);
        tick(0, 0, 0, 0, 1);
        chk("t4_rd_issued", rd_a, 1);
        wait_done(d0, 0);
        tick(0, 0, 0, 0, 1);
        chk("t4_cnt", {dbg_cnt_a, dbg_cnt_b}, {3'd1, 3'd0});

        // 5: stall with alu_ready low, then asynchronous reset mid-op
        tick(1, $urandom, 1, $urandom, 1);
        tick(0, 0, 1, $urandom, 1);
        tick(0, 0, 0, 0, 1);
        start_op(2);
        for (int i = 0; i < 10 && !alu_valid; i++) tick(0, 0, 0, 0, 0);
        chk("t5_valid_seen", alu_valid, 1);
        ha = alu_a; hb = alu_b;
        chk("t5_pair", {ha, hb}, {exp_a[idx_a], exp_b[idx_b]});
        repeat (4) begin
            tick(0, 0, 0, 0, 0);
            chk("t5_hold", {alu_valid, alu_a, alu_b}, {1'b1, ha, hb});
        end
        #2 rstn = 0;
        #1;
        chk("t5_async_rst", {rd_a, rd_b, alu_valid, alu_last, busy, done, err_ovf,
                             alu_a, alu_b, dbg_cnt_a, dbg_cnt_b}, 0);
        @(posedge clk);
        @(negedge clk);
        sample();
        @(posedge clk); #1;
        rstn = 1;

        // 6: overflow, then back-to-back issue from full queues
        repeat (6) tick(1, $urandom, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("t6_err", err_ovf, 1);
        chk("t6_cnt_a", dbg_cnt_a, 5);
        repeat (5) tick(0, 0, 1, $urandom, 1);
        tick(0, 0, 0, 0, 1);
        x0 = xfer_cnt; d0 = done_cnt;
        start_op(4);
        wait_done(d0, 0);
        chk("t6_xfers", xfer_cnt - x0, 4);
        for (int i = 0; i < 3; i++)
            chk("t6_gap", xfer_cyc[x0 + i + 1] - xfer_cyc[x0 + i], SPACING);
        chk("t6_err_cleared", err_ovf, 0);

        // randomized ops with background enqueues and random ready
        repeat (25) begin
            v = $urandom_range(1, 6);
            x0 = xfer_cnt; d0 = done_cnt;
            start_op(v);
            wait_done(d0, 1);
            chk("rnd_xfers", xfer_cnt - x0, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
